result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Fabric-to-HPS return path for one force-calculation frame; mirror of the HPS-to-fabric body loader.
- Accepts per-body acceleration results (ax, ay) from the neighborhoods over a valid/ready handshake and stores them by body index in M10K.
- Counts accepted results and raises o_done when all N bodies are in.
- The HPS reads stored results back through a second M10K port.

Parameters:
max_m10k_size, 4096, depth of each result memory (bodies)
m10k_address_len, 12, width of body index / memory address

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_start  in  1  single-cycle pulse: begin a new collection frame
i_hps_number_of_bodies  in  m10k_address_len  N, bodies expected this frame
i_result_valid  in  1  result beat present
o_result_ready  out  1  collector can accept a beat this cycle
i_result_index  in  m10k_address_len  body index of the beat
i_result_ax  in  32  x acceleration
i_result_ay  in  32  y acceleration
i_hps_read_index  in  m10k_address_len  HPS read address
o_hps_ax  out  32  stored ax at the previous cycle's i_hps_read_index
o_hps_ay  out  32  stored ay at the previous cycle's i_hps_read_index
o_count  out  m10k_address_len  results accepted this frame
o_done  out  1  all N results collected
o_error  out  1  sticky: a beat with index >= N was seen this frame

Behaviour:
- Reset (i_rst=0 at posedge):
  - state=IDLE, o_count=0, o_done=0, o_error=0, o_result_ready=0.
  - Memory contents are not cleared.
  - Reset mid-frame abandons the frame; partial writes remain in memory.
- States: IDLE(2'b00), COLLECT(2'b01), DONE(2'b10). Encoding 2'b11 is illegal and returns to IDLE next cycle.
- o_result_ready = (state==COLLECT) && !i_start. The combinational dependency on i_start is intentional.
- Accept = i_result_valid && o_result_ready.
- IDLE:
  - i_start with N>0 -> COLLECT; o_count<=0, o_error<=0.
  - i_start with N==0 -> DONE directly; o_count<=0.
- COLLECT, on accept with i_result_index < N:
  - Write ax and ay at that index, on the same edge.
  - o_count<=o_count+1.
  - If o_count==N-1 before the increment -> DONE next cycle; o_done=1 on the same edge that o_count becomes N.
- COLLECT, on accept with i_result_index >= N:
  - No write, no count change.
  - o_error<=1 (sticky until next i_start or reset).
  - The beat is consumed; ready stays high.
- COLLECT, i_start: restart the frame.
  - o_count<=0, o_error<=0, stay in COLLECT. If N==0, go to DONE instead.
  - Any concurrent beat is not accepted, because ready=0 that cycle.
- DONE:
  - o_done=1, ready=0.
  - i_start -> COLLECT (or DONE if N==0), clearing count, error and done.
- Duplicate indices are not detected: a second write to the same index overwrites the first and still increments o_count.
- o_count never exceeds N. No wrap-around is possible because ready drops in DONE.
- N is sampled continuously. The HPS must hold it stable from i_start until o_done.
- HPS read port:
  - Registered M10K read, 1-cycle latency, available in every state.
  - Read-during-write to the same address returns old data.
- Memories: two m10k instances of (max_m10k_size, m10k_address_len).
  - Port a: HPS read, wren_a=0.
  - Port b: result write, wren_b=accept && index<N.

Test Plan:
- N=4; start; beats idx 2,0,3,1 with ax=idx*10, ay=idx*20, valid every cycle -> o_count steps 1..4; o_done=1 the cycle after the 4th accept edge; ready=0 in DONE; HPS reads idx 0..3 one cycle later return (0,0),(10,20),(20,40),(30,60).
- N=4; start; beat idx 5, then idx 0..3 -> o_error=1 after first beat, o_count unaffected by it, o_done after idx 3; next i_start clears o_error to 0.
- N=3; start; 2 beats; i_start again with valid=1 that cycle -> ready=0 that cycle, o_count=0, state COLLECT; 3 further beats -> o_done.
- N=0; start -> o_done=1 next cycle, o_count=0, ready never asserts.
- N=2; valid with gaps (1 cycle on, 2 off) -> only valid cycles counted; o_count=2, o_done=1; extra valid in DONE is not accepted and o_count stays 2.
- Reset asserted mid-frame at o_count=2 of N=4 -> o_count=0, o_done=0, o_error=0, ready=0 next cycle; HPS read of idx written before reset still returns the written data.

Source files
------------

// File: rtl/result_collector.sv
// result_collector
//   Fabric-to-HPS return path for one force-calculation frame. Per-body
//   acceleration results arrive over a valid/ready handshake. They are stored
//   by body index in two M10K memories, one for ax and one for ay. The HPS
//   reads them back through the second memory port.
//
//   Ports
//     i_clk                  clock
//     i_rst                  synchronous reset, active-low
//     i_start                one-cycle pulse that begins a new frame
//     i_hps_number_of_bodies N, the number of results expected this frame
//     i_result_valid/o_result_ready/i_result_index/i_result_ax/i_result_ay
//                            result beat handshake and payload
//     i_hps_read_index       HPS read address (registered read, 1-cycle latency)
//     o_hps_ax/o_hps_ay      stored results at the previous cycle's read index
//     o_count                results accepted this frame
//     o_done                 all N results collected
//     o_error                sticky: a beat with index >= N was seen this frame

// Simple dual-port M10K model.
// Port a is read/write with a registered read. Port b is write-only.
// A read that hits the same address as a write on the same edge returns the
// old data.
module m10k #(
  parameter int max_m10k_size    = 4096,
  parameter int m10k_address_len = 12
) (
  input  logic                        clk_i,
  input  logic [m10k_address_len-1:0] address_a_i,
  input  logic                        wren_a_i,
  input  logic [31:0]                 data_a_i,
  output logic [31:0]                 q_a_o,
  input  logic [m10k_address_len-1:0] address_b_i,
  input  logic                        wren_b_i,
  input  logic [31:0]                 data_b_i
);
  logic [31:0] mem_q [max_m10k_size];

  always_ff @(posedge clk_i) begin
    if (wren_a_i) mem_q[address_a_i] <= data_a_i;
    if (wren_b_i) mem_q[address_b_i] <= data_b_i;
    q_a_o <= mem_q[address_a_i];
  end
endmodule

module result_collector #(
  parameter int max_m10k_size    = 4096,
  parameter int m10k_address_len = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [m10k_address_len-1:0] i_hps_number_of_bodies,
  input  logic                        i_result_valid,
  output logic                        o_result_ready,
  input  logic [m10k_address_len-1:0] i_result_index,
  input  logic [31:0]                 i_result_ax,
  input  logic [31:0]                 i_result_ay,
  input  logic [m10k_address_len-1:0] i_hps_read_index,
  output logic [31:0]                 o_hps_ax,
  output logic [31:0]                 o_hps_ay,
  output logic [m10k_address_len-1:0] o_count,
  output logic                        o_done,
  output logic                        o_error
);
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COLLECT = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  localparam logic [m10k_address_len-1:0] ONE = {{(m10k_address_len-1){1'b0}}, 1'b1};

  logic [1:0]                  state_q, state_d;
  logic [m10k_address_len-1:0] count_q, count_d;
  logic                        error_q, error_d;

  logic       accept;
  logic       index_ok;
  logic       wr_en;
  logic [1:0] start_state;

  // Ready drops in the i_start cycle so a restart never races a beat.
  assign o_result_ready = (state_q == ST_COLLECT) && !i_start;
  assign accept         = i_result_valid && o_result_ready;
  assign index_ok       = i_result_index < i_hps_number_of_bodies;
  assign wr_en          = accept && index_ok;

  // An empty frame skips collection entirely.
  assign start_state = (i_hps_number_of_bodies == '0) ? ST_DONE : ST_COLLECT;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = start_state;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (i_start) begin
          state_d = start_state;
          count_d = '0;
          error_d = 1'b0;
        end else if (accept) begin
          if (index_ok) begin
            count_d = count_q + ONE;
            if (count_q == i_hps_number_of_bodies - ONE) state_d = ST_DONE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign o_count = count_q;
  assign o_error = error_q;
  assign o_done  = (state_q == ST_DONE);

  m10k #(
    .max_m10k_size   (max_m10k_size),
    .m10k_address_len(m10k_address_len)
  ) u_mem_ax (
    .clk_i      (i_clk),
    .address_a_i(i_hps_read_index),
    .wren_a_i   (1'b0),
    .data_a_i   (32'd0),
    .q_a_o      (o_hps_ax),
    .address_b_i(i_result_index),
    .wren_b_i   (wr_en),
    .data_b_i   (i_result_ax)
  );

  m10k #(
    .max_m10k_size   (max_m10k_size),
    .m10k_address_len(m10k_address_len)
  ) u_mem_ay (
    .clk_i      (i_clk),
    .address_a_i(i_hps_read_index),
    .wren_a_i   (1'b0),
    .data_a_i   (32'd0),
    .q_a_o      (o_hps_ay),
    .address_b_i(i_result_index),
    .wren_b_i   (wr_en),
    .data_b_i   (i_result_ay)
  );
endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;
  localparam int AW = 12;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] i_hps_number_of_bodies;
  logic          i_result_valid;
  logic          o_result_ready;
  logic [AW-1:0] i_result_index;
  logic [31:0]   i_result_ax;
  logic [31:0]   i_result_ay;
  logic [AW-1:0] i_hps_read_index;
  logic [31:0]   o_hps_ax;
  logic [31:0]   o_hps_ay;
  logic [AW-1:0] o_count;
  logic          o_done;
  logic          o_error;

  result_collector #(.max_m10k_size(4096), .m10k_address_len(AW)) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_start               (i_start),
    .i_hps_number_of_bodies(i_hps_number_of_bodies),
    .i_result_valid        (i_result_valid),
    .o_result_ready        (o_result_ready),
    .i_result_index        (i_result_index),
    .i_result_ax           (i_result_ax),
    .i_result_ay           (i_result_ay),
    .i_hps_read_index      (i_hps_read_index),
    .o_hps_ax              (o_hps_ax),
    .o_hps_ay              (o_hps_ay),
    .o_count               (o_count),
    .o_done                (o_done),
    .o_error               (o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame bookkeeping plus a sparse image of the memories.
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_err    = 0;
  int          m_cnt    = 0;
  logic [31:0] m_ax [int];
  logic [31:0] m_ay [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the inputs currently driven (set just after a negedge).
  task automatic tick();
    int          n, idx, rd;
    bit          rd_known;
    logic [31:0] rd_ax, rd_ay;
    #1;
    check("ready", {31'd0, o_result_ready}, {31'd0, (m_active && !i_start)});
    n  = int'(i_hps_number_of_bodies);
    idx = int'(i_result_index);
    rd = int'(i_hps_read_index);
    rd_known = m_ax.exists(rd);
    rd_ax = rd_known ? m_ax[rd] : 32'd0;
    rd_ay = rd_known ? m_ay[rd] : 32'd0;
    @(posedge i_clk);
    #1;
    if (!i_rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_cnt = 0;
    end else if (i_start) begin
      m_cnt = 0; m_err = 0;
      m_active = (n != 0);
      m_done   = (n == 0);
    end else if (m_active && i_result_valid) begin
      if (idx < n) begin
        m_ax[idx] = i_result_ax;
        m_ay[idx] = i_result_ay;
        m_cnt++;
        if (m_cnt == n) begin
          m_active = 0;
          m_done   = 1;
        end
      end else begin
        m_err = 1;
      end
    end
    check("count", 32'(o_count), 32'(m_cnt));
    check("done",  {31'd0, o_done},  {31'd0, m_done});
    check("error", {31'd0, o_error}, {31'd0, m_err});
    if (rd_known) begin
      check("hps_ax", o_hps_ax, rd_ax);
      check("hps_ay", o_hps_ay, rd_ay);
    end
    @(negedge i_clk);
  endtask

  task automatic drive(input bit start, input bit valid, input int idx,
                       input logic [31:0] ax, input logic [31:0] ay, input int rd);
    i_start          = start;
    i_result_valid   = valid;
    i_result_index   = AW'(idx);
    i_result_ax      = ax;
    i_result_ay      = ay;
    i_hps_read_index = AW'(rd);
    tick();
  endtask

  task automatic idle(input int rd);
    drive(0, 0, 0, 32'd0, 32'd0, rd);
  endtask

  initial begin
    int order [4];
    int n;
    bit rnd_valid, rnd_start;
    i_rst = 0; i_start = 0; i_hps_number_of_bodies = '0; i_result_valid = 0;
    i_result_index = '0; i_result_ax = '0; i_result_ay = '0; i_hps_read_index = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    idle(0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_done",  {31'd0, o_done}, 32'd0);
    check("rst_ready", {31'd0, o_result_ready}, 32'd0);
    i_rst = 1;
    idle(0);

    // Basic frame, out-of-order indices.
    i_hps_number_of_bodies = AW'(4);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    order = '{2, 0, 3, 1};
    foreach (order[k]) drive(0, 1, order[k], 32'(order[k] * 10), 32'(order[k] * 20), 0);
    check("t1_done", {31'd0, o_done}, 32'd1);
    check("t1_count", 32'(o_count), 32'd4);
    for (int i = 0; i < 4; i++) drive(0, 1, i, 32'hdead, 32'hbeef, i);
    idle(3);
    check("t1_ay3", o_hps_ay, 32'd60);

    // Out-of-range beat raises the sticky error.
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    drive(0, 1, 5, 32'h5555, 32'h5555, 0);
    check("t2_err", {31'd0, o_error}, 32'd1);
    for (int i = 0; i < 4; i++) drive(0, 1, i, 32'(100 + i), 32'(200 + i), i);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    check("t2_err_clr", {31'd0, o_error}, 32'd0);

    // Restart mid-frame with a concurrent beat.
    i_hps_number_of_bodies = AW'(3);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    drive(0, 1, 0, 32'd7, 32'd8, 0);
    drive(0, 1, 1, 32'd9, 32'd10, 1);
    drive(1, 1, 2, 32'h77, 32'h88, 2);
    check("t3_restart_cnt", 32'(o_count), 32'd0);
    for (int i = 0; i < 3; i++) drive(0, 1, i, 32'(300 + i), 32'(400 + i), i);
    check("t3_done", {31'd0, o_done}, 32'd1);

    // Empty frame.
    i_hps_number_of_bodies = AW'(0);
    drive(1, 1, 0, 32'd1, 32'd1, 0);
    check("t4_done", {31'd0, o_done}, 32'd1);
    repeat (3) drive(0, 1, 0, 32'd1, 32'd1, 0);

    // Gapped valid.
    i_hps_number_of_bodies = AW'(2);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, i, 32'(500 + i), 32'(600 + i), i);
      idle(i);
      idle(i);
    end
    drive(0, 1, 0, 32'hffff, 32'hffff, 0);
    check("t5_count", 32'(o_count), 32'd2);

    // Reset mid-frame keeps memory contents.
    i_hps_number_of_bodies = AW'(4);
    drive(1, 0, 0, 32'd0, 32'd0, 0);
    drive(0, 1, 0, 32'h1234, 32'h5678, 0);
    drive(0, 1, 1, 32'h9abc, 32'hdef0, 1);
    i_rst = 0;
    idle(0);
    i_rst = 1;
    check("t6_count", 32'(o_count), 32'd0);
    idle(1);
    check("t6_ax1", o_hps_ax, 32'h9abc);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      n = int'($urandom_range(0, 6));
      i_hps_number_of_bodies = AW'(n);
      drive(1, 0, 0, 32'd0, 32'd0, int'($urandom_range(0, 7)));
      for (int c = 0; c < 60 && !m_done; c++) begin
        if ($urandom_range(0, 79) == 0) begin
          i_rst = 0;
          idle(int'($urandom_range(0, 7)));
          i_rst = 1;
          drive(1, 0, 0, 32'd0, 32'd0, 0);
        end
        rnd_valid = ($urandom_range(0, 2) != 0);
        rnd_start = ($urandom_range(0, 39) == 0);
        drive(rnd_start, rnd_valid, int'($urandom_range(0, n + 1)), $urandom, $urandom,
              int'($urandom_range(0, 7)));
      end
      if (!m_done) begin
        n_vec++;
        n_err++;
        $error("FAIL rand_frame_timeout: frame %0d count %0d expected done", f, o_count);
      end
      idle(int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
